// File: rtl/seqdec_gen.sv
// Parametrised serial sequence detector with a run-time loaded pattern and a saturating match count.
// Build option SEQDEC_MASK_EN adds a per-bit compare mask latched alongside the pattern.
module seqdec_gen #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             in_a_i,
    input  logic             in_valid_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] pattern_i,
`ifdef SEQDEC_MASK_EN
    input  logic [WIDTH-1:0] mask_i,
`endif
    input  logic             overlap_i,
    output logic             armed_o,
    output logic             out_o,
    output logic [CNT_W-1:0] match_cnt_o
);
    // state    | meaning
    // ST_IDLE  | no pattern loaded since reset; input bits ignored
    // ST_FILL  | fewer than WIDTH bits accepted since Load or last non-overlapped match
    // ST_RUN   | history holds the last WIDTH accepted bits
    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_RUN} state_t;

    localparam int FW = $clog2(WIDTH + 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic             out_q, out_d;
    logic [WIDTH-1:0] mask_eff;
    logic [WIDTH-1:0] hist_shift;
    logic [FW-1:0]    fill_inc;
    logic             hit;

`ifdef SEQDEC_MASK_EN
    logic [WIDTH-1:0] mask_q, mask_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) mask_q <= '1;
        else         mask_q <= mask_d;
    end

    always_comb begin
        mask_d = mask_q;
        if (load_i) mask_d = mask_i;
    end

    assign mask_eff = mask_q;
`else
    assign mask_eff = '1;
`endif

    // Shift form keeps every history bit in the expression; the MSB simply falls off.
    assign hist_shift = (hist_q << 1) | WIDTH'(in_a_i);
    assign fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
    assign hit        = (((hist_shift ^ pat_q) & mask_eff) == '0);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= '0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        out_d   = 1'b0;
        if (load_i) begin
            pat_d   = pattern_i;
            hist_d  = '0;
            fill_d  = '0;
            cnt_d   = '0;
            armed_d = 1'b1;
            state_d = ST_FILL;
        end else if (in_valid_i && (state_q != ST_IDLE)) begin
            hist_d = hist_shift;
            fill_d = fill_inc;
            if (fill_inc == FILL_FULL) begin
                state_d = ST_RUN;
                if (hit) begin
                    out_d = 1'b1;
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    if (!overlap_i) begin
                        hist_d  = '0;
                        fill_d  = '0;
                        state_d = ST_FILL;
                    end
                end
            end
        end
    end

    assign armed_o     = armed_q;
    assign out_o       = out_q;
    assign match_cnt_o = cnt_q;

endmodule
